// File: rtl/irq_ctl_pkg.sv
// irq_ctl shared definitions
// register map, vector width, encoder result
package irq_ctl_pkg;

  localparam int MAX_SRC = 16;
  localparam int VEC_W   = 4;

  localparam logic [1:0] ADDR_PEND = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;

  typedef struct packed {
    logic             any;
    logic [VEC_W-1:0] vec;
  } prio_t;

endpackage

// File: rtl/irq_ctl_if.sv
// irq_ctl I/O bus interface
// same en/wr/addr protocol as the timer
interface irq_ctl_if;

  logic        en;
  logic        wr;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        wt;

  modport master (
    output en, wr, addr, data_in,
    input  data_out, wt
  );

  modport slave (
    input  en, wr, addr, data_in,
    output data_out, wt
  );

endinterface

// File: rtl/irq_ctl_prio_enc.sv
// irq_ctl priority encoder
// lowest set index wins, combinational
module irq_prio_enc
  import irq_ctl_pkg::*;
(
  input  logic [MAX_SRC-1:0] req,
  output prio_t              res
);

  logic found;

  // scan upward, first hit is the highest priority
  always_comb begin
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_SRC; i++) begin
      if (req[i] && !found) begin
        found   = 1'b1;
        res.any = 1'b1;
        res.vec = VEC_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctl.sv
// irq_ctl top: latch, mask, resolve
// one registered request and vector to the CPU
module irq_ctl
  import irq_ctl_pkg::*;
#(
  parameter int NUM_SRC = 16
) (
  input  logic               clk,
  input  logic               reset,
  irq_ctl_if.slave           bus,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               irq_ack,
  output logic               irq_out,
  output logic [VEC_W-1:0]   irq_vec
);

  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] edge_q, edge_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] src_prev_q, src_prev_d;
  logic               irq_out_q, irq_out_d;
  logic [VEC_W-1:0]   irq_vec_q, irq_vec_d;

  logic [NUM_SRC-1:0] wdata;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] ack_hit;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] chg;
  logic [MAX_SRC-1:0] act_w;
  logic [31:0]        rd;
  logic               wr_pend;
  logic               wr_mask;
  logic               wr_edge;
  prio_t              prio;
  logic               unused_din;

  assign wdata      = bus.data_in[NUM_SRC-1:0];
  assign unused_din = ^bus.data_in;

  // write strobes per register
  always_comb begin
    wr_pend = bus.en & bus.wr & (bus.addr == ADDR_PEND);
    wr_mask = bus.en & bus.wr & (bus.addr == ADDR_MASK);
    wr_edge = bus.en & bus.wr & (bus.addr == ADDR_EDGE);
  end

  // ack only lands on the vector being presented
  always_comb begin
    ack_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ack_hit[i] = irq_ack & irq_out_q &
                   (irq_vec_q == VEC_W'(i));
    end
  end

  assign rise = irq_src & ~src_prev_q;
  assign clr  = (wr_pend ? wdata : '0) | ack_hit;
  assign chg  = wr_edge ? (wdata ^ edge_q) : '0;

  // edge bits: set beats clear; level bits track src
  always_comb begin
    pend_d = (edge_q & (rise | (pend_q & ~clr)))
           | (~edge_q & irq_src);
    pend_d = pend_d & ~chg;
    mask_d = wr_mask ? wdata : mask_q;
    edge_d = wr_edge ? wdata : edge_q;
    src_prev_d = irq_src;
  end

  // widen active set to the encoder width
  always_comb begin
    act_w = '0;
    act_w[NUM_SRC-1:0] = pend_q & mask_q;
  end

  irq_prio_enc u_enc (
    .req (act_w),
    .res (prio)
  );

  assign irq_out_d = prio.any;
  assign irq_vec_d = prio.vec;

  // register readback
  always_comb begin
    rd = '0;
    unique case (bus.addr)
      ADDR_PEND: rd[NUM_SRC-1:0] = pend_q;
      ADDR_MASK: rd[NUM_SRC-1:0] = mask_q;
      ADDR_EDGE: rd[NUM_SRC-1:0] = edge_q;
      ADDR_STAT: rd = {irq_out_q, 27'b0, irq_vec_q};
      default:   rd = '0;
    endcase
  end

  assign bus.data_out = rd;
  assign bus.wt       = 1'b0;
  assign irq_out      = irq_out_q;
  assign irq_vec      = irq_vec_q;

  // state registers, reset discards everything
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q     <= '0;
      edge_q     <= '0;
      pend_q     <= '0;
      src_prev_q <= '0;
      irq_out_q  <= 1'b0;
      irq_vec_q  <= '0;
    end else begin
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      pend_q     <= pend_d;
      src_prev_q <= src_prev_d;
      irq_out_q  <= irq_out_d;
      irq_vec_q  <= irq_vec_d;
    end
  end

endmodule

// File: tb/tb_irq_ctl.sv
// irq_ctl bench: 16- and 4-source instances
// random + directed stimulus, queued expectations
module tb_irq_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] src;
  logic        ack;
  logic        o16, o4;
  logic [3:0]  v16, v4;

  always #5 clk = ~clk;

  irq_ctl_if b16 ();
  irq_ctl_if b4 ();

  irq_ctl #(.NUM_SRC(16)) dut16 (
    .clk     (clk),
    .reset   (reset),
    .bus     (b16),
    .irq_src (src),
    .irq_ack (ack),
    .irq_out (o16),
    .irq_vec (v16)
  );

  irq_ctl #(.NUM_SRC(4)) dut4 (
    .clk     (clk),
    .reset   (reset),
    .bus     (b4),
    .irq_src (src[3:0]),
    .irq_ack (ack),
    .irq_out (o4),
    .irq_vec (v4)
  );

  typedef struct packed {
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        o0;
    logic        o1;
    logic [3:0]  v0;
    logic [3:0]  v1;
  } exp_t;

  exp_t q[$];
  event mon_ev;
  int   errs   = 0;
  int   checks = 0;

  logic [15:0] m_mask [2];
  logic [15:0] m_edge [2];
  logic [15:0] m_pend [2];
  logic [15:0] m_prev [2];
  logic        m_out  [2];
  logic [3:0]  m_vec  [2];

  function automatic logic [31:0] m_read(int k, logic [1:0] a);
    case (a)
      2'd0:    return {16'h0, m_pend[k]};
      2'd1:    return {16'h0, m_mask[k]};
      2'd2:    return {16'h0, m_edge[k]};
      default: return {m_out[k], 27'b0, m_vec[k]};
    endcase
  endfunction

  // behavioural rules applied at one clock edge
  function automatic void m_step(int k, logic r, logic [15:0] s,
                                 logic a, logic e, logic w,
                                 logic [1:0] ad, logic [31:0] d);
    logic [15:0] lim, nx, act, wd;
    bit          hit;
    lim = (k == 0) ? 16'hFFFF : 16'h000F;
    if (r) begin
      m_mask[k] = 0; m_edge[k] = 0; m_pend[k] = 0;
      m_prev[k] = 0; m_out[k] = 0; m_vec[k] = 0;
      return;
    end
    s   = s & lim;
    wd  = d[15:0] & lim;
    act = m_pend[k] & m_mask[k];
    nx  = m_pend[k];
    if (e && w && ad == 2'd0) nx = nx & ~(wd & m_edge[k]);
    if (a && m_out[k] && m_edge[k][m_vec[k]]) nx[m_vec[k]] = 1'b0;
    nx = nx | (s & ~m_prev[k] & m_edge[k]);
    nx = (nx & m_edge[k]) | (s & ~m_edge[k]);
    if (e && w && ad == 2'd2) begin
      nx = nx & ~(wd ^ m_edge[k]);
      m_edge[k] = wd;
    end
    if (e && w && ad == 2'd1) m_mask[k] = wd;
    m_pend[k] = nx;
    m_prev[k] = s;
    m_out[k]  = (act != 0);
    m_vec[k]  = 4'd0;
    hit = 0;
    for (int i = 0; i < 16; i++) begin
      if (!hit && act[i]) begin
        m_vec[k] = 4'(i);
        hit = 1;
      end
    end
  endfunction

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic cyc(logic r, logic [15:0] s, logic a, logic e,
                     logic w, logic [1:0] ad, logic [31:0] d);
    exp_t x;
    @(negedge clk);
    reset = r; src = s; ack = a;
    b16.en = e; b16.wr = w; b16.addr = ad; b16.data_in = d;
    b4.en  = e; b4.wr  = w; b4.addr  = ad; b4.data_in  = d;
    #1;
    x.rd0 = m_read(0, ad);
    x.rd1 = m_read(1, ad);
    x.o0  = m_out[0];
    x.o1  = m_out[1];
    x.v0  = m_vec[0];
    x.v1  = m_vec[1];
    q.push_back(x);
    -> mon_ev;
    m_step(0, r, s, a, e, w, ad, d);
    m_step(1, r, s, a, e, w, ad, d);
  endtask

  task automatic wreg(logic [1:0] ad, logic [31:0] d);
    cyc(1'b0, src, 1'b0, 1'b1, 1'b1, ad, d);
  endtask

  task automatic rreg(logic [1:0] ad);
    cyc(1'b0, src, 1'b0, 1'b1, 1'b0, ad, 32'h0);
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b0, src, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic drive(logic [15:0] s);
    cyc(1'b0, s, 1'b0, 1'b0, 1'b0, 2'd3, 32'h0);
  endtask

  task automatic do_ack();
    cyc(1'b0, src, 1'b1, 1'b0, 1'b0, 2'd3, 32'h0);
  endtask

  // monitor: compare DUT against the oldest expectation
  initial begin
    exp_t x;
    forever begin
      @(mon_ev);
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL scoreboard empty t=%0t", $time);
      end else begin
        x = q.pop_front();
        check("rd16",  b16.data_out, x.rd0);
        check("rd4",   b4.data_out,  x.rd1);
        check("out16", {31'b0, o16}, {31'b0, x.o0});
        check("out4",  {31'b0, o4},  {31'b0, x.o1});
        check("vec16", {28'b0, v16}, {28'b0, x.v0});
        check("vec4",  {28'b0, v4},  {28'b0, x.v1});
        check("wt16",  {31'b0, b16.wt}, 32'h0);
        check("wt4",   {31'b0, b4.wt},  32'h0);
      end
    end
  end

  initial begin
    logic [15:0] s;
    logic        r, a, e, w;
    logic [1:0]  ad;
    logic [31:0] d;
    reset = 1'b1; src = '0; ack = 1'b0;
    b16.en = 0; b16.wr = 0; b16.addr = 0; b16.data_in = 0;
    b4.en  = 0; b4.wr  = 0; b4.addr  = 0; b4.data_in  = 0;
    for (int k = 0; k < 2; k++) begin
      m_mask[k] = 0; m_edge[k] = 0; m_pend[k] = 0;
      m_prev[k] = 0; m_out[k] = 0; m_vec[k] = 0;
    end
    repeat (2) @(posedge clk);
    cyc(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    for (int i = 0; i < 4; i++) rreg(2'(i));

    wreg(2'd1, 32'h4000);
    wreg(2'd2, 32'h0);
    drive(16'h4000);
    rreg(2'd0);
    rreg(2'd3);
    do_ack();
    rreg(2'd3);
    drive(16'h0);
    idle(3);

    wreg(2'd2, 32'h3);
    wreg(2'd1, 32'h3);
    drive(16'h2);
    drive(16'h0);
    idle(3);
    drive(16'h1);
    drive(16'h0);
    idle(2);
    do_ack();
    rreg(2'd0);
    rreg(2'd3);
    do_ack();
    idle(2);

    wreg(2'd2, 32'h8);
    drive(16'h8);
    drive(16'h0);
    cyc(1'b0, 16'h8, 1'b0, 1'b1, 1'b1, 2'd0, 32'h8);
    rreg(2'd0);

    wreg(2'd2, 32'h24);
    drive(16'h24);
    drive(16'h0);
    wreg(2'd1, 32'h20);
    idle(2);
    rreg(2'd3);
    wreg(2'd1, 32'h24);
    rreg(2'd3);
    rreg(2'd3);
    wreg(2'd1, 32'h0);
    idle(1);
    rreg(2'd0);
    rreg(2'd3);

    wreg(2'd2, 32'hFFFF);
    rreg(2'd2);
    rreg(2'd0);
    wreg(2'd1, 32'hFFFF_FFFF);
    rreg(2'd1);

    for (int n = 0; n < 1500; n++) begin
      s = src;
      for (int b = 0; b < 16; b++)
        if ($urandom_range(7) == 0) s[b] = ~s[b];
      r  = ($urandom_range(199) == 0);
      a  = ($urandom_range(3) == 0);
      e  = ($urandom_range(2) == 0);
      w  = 1'($urandom_range(1));
      ad = 2'($urandom_range(3));
      d  = $urandom;
      cyc(r, s, a, e, w, ad, d);
    end
    idle(3);

    @(negedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL scoreboard leftover got=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
